// File: rtl/apb_mon_pkg.sv
// Shared constants for the APB configuration monitor.
// Optional shadow-register build: define APB_MON_SHADOW_EN.
package apb_mon_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_SETUP_SKIP = 3'd1,
        ERR_UNSTABLE   = 3'd2,
        ERR_ABORT      = 3'd3,
        ERR_RANGE      = 3'd4,
        ERR_ORDER      = 3'd5,
        ERR_ADDR       = 3'd6
    } err_code_e;

    // Entry i is the inclusive range of register address i.
    localparam int RNG_N = 10;
    localparam logic [9:0][9:0] RNG_LO = {
        10'd30, 10'd20, 10'd90, 10'd80, 10'd1,
        10'd1, 10'd200, 10'd200, 10'd1, 10'd0
    };
    localparam logic [9:0][9:0] RNG_HI = {
        10'd40, 10'd40, 10'd99, 10'd99, 10'd20,
        10'd72, 10'd720, 10'd720, 10'd255, 10'd1
    };
    localparam logic [9:0] RNG_HI_DFLT = 10'd255;

    localparam logic [9:0] SH_W_RST    = 10'd720;
    localparam logic [9:0] SH_H_RST    = 10'd720;
    localparam logic [9:0] SH_AMAX_RST = 10'd99;
    localparam logic [9:0] SH_BMAX_RST = 10'd40;
    localparam logic [9:0] SH_AMIN     = 10'd80;
    localparam logic [9:0] SH_BMIN     = 10'd20;

endpackage

// File: rtl/apb_cfg_monitor_if.sv
// APB request-side signals observed by the monitor.
interface apb_cfg_monitor_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;

    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA);
endinterface

// File: rtl/apb_mon_range.sv
// Address -> allowed write-data range; hi of 6 and 8 come from
// amax_i/bmax_i so the shadow build can narrow them.
module apb_mon_range
    import apb_mon_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] amax_i,
    input  logic [DATA_W-1:0] bmax_i,
    output logic [DATA_W-1:0] lo_o,
    output logic [DATA_W-1:0] hi_o
);
    always_comb begin
        lo_o = '0;
        hi_o = DATA_W'(RNG_HI_DFLT);
        if (addr_i < ADDR_W'(RNG_N)) begin
            lo_o = DATA_W'(RNG_LO[addr_i[3:0]]);
            hi_o = DATA_W'(RNG_HI[addr_i[3:0]]);
            if (addr_i[3:0] == 4'd6) hi_o = amax_i;
            if (addr_i[3:0] == 4'd8) hi_o = bmax_i;
        end
    end
endmodule

// File: rtl/apb_cfg_monitor.sv
// APB protocol / config-range monitor with error capture.
// Define APB_MON_SHADOW_EN for shadowed limits (codes 5, 6).
module apb_cfg_monitor
    import apb_mon_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    apb_cfg_monitor_if.slave  apb,
    input  logic              clr,
    output logic              err_pulse,
    output logic [2:0]        err_code,
    output logic [ADDR_W-1:0] err_addr,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [6:0]        err_sticky,
    output logic [2:0]        first_code,
    output logic [CNT_W-1:0]  wr_cnt
);
    logic [1:0]        st_q, st_d;
    logic [ADDR_W-1:0] cap_addr_q;
    logic              cap_wr_q;
    logic [DATA_W-1:0] cap_data_q;
    logic              epulse_q;
    logic [2:0]        ecode_q;
    logic [ADDR_W-1:0] eaddr_q;
    logic [CNT_W-1:0]  ecnt_q, ecnt_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [6:0]        sticky_q, sticky_d;
    logic [2:0]        first_q, first_d;
    logic [2:0]        code;
    logic              recap, done, err;
    logic              unstable, oor, bad_ord, bad_adr;
    logic [DATA_W-1:0] lo, hi, amax, bmax;

    apb_mon_range #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rng (
        .addr_i (apb.PADDR),
        .amax_i (amax),
        .bmax_i (bmax),
        .lo_o   (lo),
        .hi_o   (hi)
    );

    assign unstable = (apb.PADDR != cap_addr_q) ||
                      (apb.PWRITE != cap_wr_q) ||
                      (apb.PWDATA != cap_data_q);
    assign oor = apb.PWRITE && (apb.PWDATA < lo || apb.PWDATA > hi);

`ifdef APB_MON_SHADOW_EN
    localparam int LW = 2 * DATA_W + 2;
    localparam int CW = (ADDR_W > LW) ? ADDR_W : LW;
    logic [DATA_W-1:0] sh_w_q, sh_h_q, sh_amax_q, sh_bmax_q;
    logic [CW-1:0]     lim;

    assign amax = sh_amax_q;
    assign bmax = sh_bmax_q;
    assign lim  = CW'(9) + ((CW'(sh_w_q) * CW'(sh_h_q)) << 1);
    assign bad_adr = CW'(apb.PADDR) > lim;
    assign bad_ord = apb.PWRITE &&
        ((apb.PADDR == ADDR_W'(7) && apb.PWDATA < DATA_W'(SH_AMIN)) ||
         (apb.PADDR == ADDR_W'(9) && apb.PWDATA < DATA_W'(SH_BMIN)));

    // Shadows only follow writes that completed without any error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_w_q    <= DATA_W'(SH_W_RST);
            sh_h_q    <= DATA_W'(SH_H_RST);
            sh_amax_q <= DATA_W'(SH_AMAX_RST);
            sh_bmax_q <= DATA_W'(SH_BMAX_RST);
        end else if (done && apb.PWRITE && !err) begin
            if (apb.PADDR == ADDR_W'(2)) sh_w_q    <= apb.PWDATA;
            if (apb.PADDR == ADDR_W'(3)) sh_h_q    <= apb.PWDATA;
            if (apb.PADDR == ADDR_W'(7)) sh_amax_q <= apb.PWDATA;
            if (apb.PADDR == ADDR_W'(9)) sh_bmax_q <= apb.PWDATA;
        end
    end
`else
    assign amax    = DATA_W'(SH_AMAX_RST);
    assign bmax    = DATA_W'(SH_BMAX_RST);
    assign bad_adr = 1'b0;
    assign bad_ord = 1'b0;
`endif

    // IDLE and ACCESS react identically; ACCESS only marks the beat after a transfer.
    always_comb begin
        st_d  = ST_IDLE;
        code  = ERR_NONE;
        recap = 1'b0;
        done  = 1'b0;
        case (st_q)
            ST_SETUP: begin
                if (apb.PSEL && apb.PENABLE) begin
                    st_d = ST_ACCESS;
                    done = 1'b1;
                    code = unstable ? ERR_UNSTABLE :
                           bad_adr  ? ERR_ADDR :
                           bad_ord  ? ERR_ORDER :
                           oor      ? ERR_RANGE : ERR_NONE;
                end else if (!apb.PSEL) begin
                    code = ERR_ABORT;
                end else begin
                    st_d  = ST_SETUP;
                    recap = 1'b1;
                end
            end
            default: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    st_d  = ST_SETUP;
                    recap = 1'b1;
                end else if (apb.PSEL && apb.PENABLE) begin
                    code = ERR_SETUP_SKIP;
                end
            end
        endcase
    end

    assign err = (code != 3'd0);

    // A coincident clr wipes history first, then this cycle's error lands.
    always_comb begin
        ecnt_d   = clr ? '0 : ecnt_q;
        if (err && ecnt_d != '1) ecnt_d = ecnt_d + 1'b1;
        sticky_d = (clr ? 7'd0 : sticky_q) | (err ? (7'd1 << code) : 7'd0);
        first_d  = clr ? 3'd0 : first_q;
        if (first_d == 3'd0) first_d = code;
        wcnt_d   = wcnt_q;
        if (done && apb.PWRITE && wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= ST_IDLE;
            cap_addr_q <= '0;
            cap_wr_q   <= 1'b0;
            cap_data_q <= '0;
            epulse_q   <= 1'b0;
            ecode_q    <= 3'd0;
            eaddr_q    <= '0;
            ecnt_q     <= '0;
            wcnt_q     <= '0;
            sticky_q   <= 7'd0;
            first_q    <= 3'd0;
        end else begin
            st_q     <= st_d;
            epulse_q <= err;
            ecode_q  <= code;
            eaddr_q  <= err ? apb.PADDR : '0;
            ecnt_q   <= ecnt_d;
            wcnt_q   <= wcnt_d;
            sticky_q <= sticky_d;
            first_q  <= first_d;
            if (recap) begin
                cap_addr_q <= apb.PADDR;
                cap_wr_q   <= apb.PWRITE;
                cap_data_q <= apb.PWDATA;
            end
        end
    end

    assign err_pulse  = epulse_q;
    assign err_code   = ecode_q;
    assign err_addr   = eaddr_q;
    assign err_cnt    = ecnt_q;
    assign err_sticky = sticky_q;
    assign first_code = first_q;
    assign wr_cnt     = wcnt_q;
endmodule
